// File: rtl/fir_pkg.sv
// rtl/fir_pkg.sv - shared widths, state encoding and helpers for the 4-tap FIR MAC
//
// Purpose : common definitions imported by fir_mac_4tap.
// Contents: SAMPLE_W/PROD_W/ACC_W/NTAPS widths, tap index width,
//           fir_state_e encoding (IDLE=0, MAC=1, HOLD=2),
//           widen_prod() zero-extends a product to accumulator width.
package fir_pkg;

  localparam int SAMPLE_W = 4;
  localparam int PROD_W   = 8;
  localparam int ACC_W    = 10;
  localparam int NTAPS    = 4;
  localparam int TAP_W    = $clog2(NTAPS);

  // Index of the oldest tap; reaching it ends the MAC sequence.
  localparam logic [TAP_W-1:0] LAST_TAP = TAP_W'(NTAPS - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    MAC  = 2'd1,
    HOLD = 2'd2
  } fir_state_e;

  // Products are unsigned, so widening is a plain zero-extension.
  function automatic logic [ACC_W-1:0] widen_prod(input logic [PROD_W-1:0] p);
    return {{(ACC_W - PROD_W){1'b0}}, p};
  endfunction

endpackage

// File: rtl/mul_4bit.sv
// rtl/mul_4bit.sv - unsigned 4x4 -> 8 bit combinational multiplier
//
// Purpose : shared multiplier used by the FIR MAC, one product per cycle.
// Ports   : a [3:0] in  - multiplicand (coefficient)
//           b [3:0] in  - multiplier (sample)
//           r [7:0] out - full-width unsigned product a*b
module mul_4bit (
  input  logic [3:0] a,
  input  logic [3:0] b,
  output logic [7:0] r
);

  // Operands are widened first so the product is never truncated.
  assign r = {4'd0, a} * {4'd0, b};

endmodule

// File: rtl/fir_mac_4tap.sv
// rtl/fir_mac_4tap.sv - 4-tap unsigned FIR filter with a single time-shared multiplier
//
// Purpose : accepts one sample in IDLE, walks the four taps through one
//           mul_4bit (one product per cycle), then holds the sum until
//           downstream takes it.
// Params  : C0..C3 - unsigned 4-bit coefficients, C0 on newest sample.
// Ports   : clk             in  - rising-edge clock
//           rst_n           in  - asynchronous active-low reset
//           flush           in  - zero the delay line in IDLE (only with FIR_FLUSH_EN)
//           in_valid        in  - in_sample holds a new sample
//           in_sample [3:0] in  - unsigned input sample
//           in_ready        out - block accepts a sample this cycle (IDLE only)
//           out_valid       out - out_data holds a filter result
//           out_data  [9:0] out - sum of C_k * x_k, k = 0..3
//           out_ready       in  - downstream consumes out_data this cycle
// Config  : FIR_FLUSH_EN adds the flush input; without it the delay line
//           clears only on reset.
module fir_mac_4tap
  import fir_pkg::*;
#(
  parameter logic [SAMPLE_W-1:0] C0 = 4'd1,
  parameter logic [SAMPLE_W-1:0] C1 = 4'd2,
  parameter logic [SAMPLE_W-1:0] C2 = 4'd2,
  parameter logic [SAMPLE_W-1:0] C3 = 4'd1
) (
  input  logic                clk,
  input  logic                rst_n,
`ifdef FIR_FLUSH_EN
  input  logic                flush,
`endif
  input  logic                in_valid,
  input  logic [SAMPLE_W-1:0] in_sample,
  output logic                in_ready,
  output logic                out_valid,
  output logic [ACC_W-1:0]    out_data,
  input  logic                out_ready
);

  fir_state_e          state_q, state_d;
  logic [SAMPLE_W-1:0] x0_q, x0_d;
  logic [SAMPLE_W-1:0] x1_q, x1_d;
  logic [SAMPLE_W-1:0] x2_q, x2_d;
  logic [SAMPLE_W-1:0] x3_q, x3_d;
  logic [ACC_W-1:0]    acc_q, acc_d;
  logic [TAP_W-1:0]    tap_q, tap_d;
  logic [ACC_W-1:0]    out_data_q, out_data_d;
  logic                out_valid_q, out_valid_d;

  logic                flush_w;
  logic [SAMPLE_W-1:0] coef_sel;
  logic [SAMPLE_W-1:0] samp_sel;
  logic [PROD_W-1:0]   prod;
  logic [ACC_W-1:0]    acc_sum;

`ifdef FIR_FLUSH_EN
  assign flush_w = flush;
`else
  assign flush_w = 1'b0;
`endif

  // Coefficient and sample for the current tap feed the one multiplier.
  always_comb begin
    coef_sel = C0;
    samp_sel = x0_q;
    case (tap_q)
      2'd0: begin coef_sel = C0; samp_sel = x0_q; end
      2'd1: begin coef_sel = C1; samp_sel = x1_q; end
      2'd2: begin coef_sel = C2; samp_sel = x2_q; end
      2'd3: begin coef_sel = C3; samp_sel = x3_q; end
      default: begin coef_sel = C0; samp_sel = x0_q; end
    endcase
  end

  mul_4bit u_mul (
    .a (coef_sel),
    .b (samp_sel),
    .r (prod)
  );

  assign acc_sum = acc_q + widen_prod(prod);

  always_comb begin
    state_d     = state_q;
    x0_d        = x0_q;
    x1_d        = x1_q;
    x2_d        = x2_q;
    x3_d        = x3_q;
    acc_d       = acc_q;
    tap_d       = tap_q;
    out_data_d  = out_data_q;
    out_valid_d = out_valid_q;

    case (state_q)
      IDLE: begin
        // Flush wins over a simultaneous sample, which stays unaccepted.
        if (flush_w) begin
          x0_d = '0;
          x1_d = '0;
          x2_d = '0;
          x3_d = '0;
        end else if (in_valid) begin
          x3_d    = x2_q;
          x2_d    = x1_q;
          x1_d    = x0_q;
          x0_d    = in_sample;
          acc_d   = '0;
          tap_d   = '0;
          state_d = MAC;
        end
      end

      MAC: begin
        acc_d = acc_sum;
        tap_d = tap_q + TAP_W'(1);
        if (tap_q == LAST_TAP) begin
          // The last product goes straight into out_data so the result is
          // visible on the same edge the sequence finishes.
          out_data_d  = acc_sum;
          out_valid_d = 1'b1;
          tap_d       = '0;
          state_d     = HOLD;
        end
      end

      HOLD: begin
        if (out_valid_q && out_ready) begin
          out_valid_d = 1'b0;
          state_d     = IDLE;
        end
      end

      default: begin
        state_d     = IDLE;
        out_valid_d = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      x0_q        <= '0;
      x1_q        <= '0;
      x2_q        <= '0;
      x3_q        <= '0;
      acc_q       <= '0;
      tap_q       <= '0;
      out_data_q  <= '0;
      out_valid_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      x0_q        <= x0_d;
      x1_q        <= x1_d;
      x2_q        <= x2_d;
      x3_q        <= x3_d;
      acc_q       <= acc_d;
      tap_q       <= tap_d;
      out_data_q  <= out_data_d;
      out_valid_q <= out_valid_d;
    end
  end

  assign in_ready  = (state_q == IDLE);
  assign out_valid = out_valid_q;
  assign out_data  = out_data_q;

endmodule

// File: tb/tb_fir_mac_4tap.sv
// tb/tb_fir_mac_4tap.sv - directed self-checking bench for fir_mac_4tap
module tb_fir_mac_4tap;

  logic       clk;
  logic       rst_n;
  logic       in_valid;
  logic [3:0] in_sample;
  logic       out_ready;
  logic       in_ready, in_ready2;
  logic       out_valid, out_valid2;
  logic [9:0] out_data, out_data2;
`ifdef FIR_FLUSH_EN
  logic       flush;
`endif

  int tests_run    = 0;
  int tests_failed = 0;

  fir_mac_4tap dut (
    .clk       (clk),
    .rst_n     (rst_n),
`ifdef FIR_FLUSH_EN
    .flush     (flush),
`endif
    .in_valid  (in_valid),
    .in_sample (in_sample),
    .in_ready  (in_ready),
    .out_valid (out_valid),
    .out_data  (out_data),
    .out_ready (out_ready)
  );

  fir_mac_4tap #(.C0(4'd15), .C1(4'd15), .C2(4'd15), .C3(4'd15)) dut_fs (
    .clk       (clk),
    .rst_n     (rst_n),
`ifdef FIR_FLUSH_EN
    .flush     (flush),
`endif
    .in_valid  (in_valid),
    .in_sample (in_sample),
    .in_ready  (in_ready2),
    .out_valid (out_valid2),
    .out_data  (out_data2),
    .out_ready (out_ready)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic do_reset;
    @(negedge clk);
    rst_n    = 1'b0;
    in_valid = 1'b0;
    @(negedge clk);
    rst_n    = 1'b1;
  endtask

  // Offers one sample, then reports the result and its latency in edges
  // after the acceptance edge (-1 if it never appeared).
  task automatic push(input logic [3:0] s, output logic [9:0] d, output logic [9:0] d2,
                      output int lat);
    int n;
    n = 0;
    @(negedge clk);
    while (!in_ready && n < 20) begin
      @(negedge clk);
      n++;
    end
    in_valid  = 1'b1;
    in_sample = s;
    @(posedge clk);
    #1;
    in_valid  = 1'b0;
    in_sample = 4'd0;
    lat = -1;
    d   = '0;
    d2  = '0;
    for (int i = 1; i <= 20; i++) begin
      @(posedge clk);
      #1;
      if (out_valid) begin
        lat = i;
        d   = out_data;
        d2  = out_data2;
        break;
      end
    end
  endtask

  task automatic test_reset;
    rst_n     = 1'b0;
    in_valid  = 1'b0;
    in_sample = 4'd0;
    out_ready = 1'b0;
`ifdef FIR_FLUSH_EN
    flush     = 1'b0;
`endif
    #23;
    tests_run++;
    if (out_valid !== 1'b0 || out_data !== 10'd0) begin
      tests_failed++;
      $display("FAIL reset_outputs: got valid=%b data=%0d expected valid=0 data=0", out_valid, out_data);
    end
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    tests_run++;
    if (in_ready !== 1'b1) begin
      tests_failed++;
      $display("FAIL reset_in_ready: got %b expected 1", in_ready);
    end
    tests_run++;
    if (out_valid !== 1'b0) begin
      tests_failed++;
      $display("FAIL reset_out_valid_after_release: got %b expected 0", out_valid);
    end
  endtask

  task automatic test_impulse;
    logic [3:0] samp [5] = '{4'd15, 4'd0, 4'd0, 4'd0, 4'd0};
    logic [9:0] expv [5] = '{10'd15, 10'd30, 10'd30, 10'd15, 10'd0};
    logic [9:0] d, d2;
    int lat;
    out_ready = 1'b1;
    for (int i = 0; i < 5; i++) begin
      push(samp[i], d, d2, lat);
      tests_run++;
      if (lat != 4) begin
        tests_failed++;
        $display("FAIL impulse_latency[%0d]: got %0d expected 4", i, lat);
      end
      tests_run++;
      if (d !== expv[i]) begin
        tests_failed++;
        $display("FAIL impulse_data[%0d]: got %0d expected %0d", i, d, expv[i]);
      end
    end
  endtask

  task automatic test_full_scale;
    logic [9:0] expv [5] = '{10'd225, 10'd450, 10'd675, 10'd900, 10'd900};
    logic [9:0] d, d2;
    int lat;
    out_ready = 1'b1;
    for (int i = 0; i < 5; i++) begin
      push(4'd15, d, d2, lat);
      tests_run++;
      if (lat != 4 || d2 !== expv[i]) begin
        tests_failed++;
        $display("FAIL full_scale[%0d]: got data=%0d lat=%0d expected data=%0d lat=4", i, d2, lat, expv[i]);
      end
    end
  endtask

  task automatic test_backpressure;
    logic [9:0] d, d2;
    int lat;
    do_reset;
    out_ready = 1'b0;
    push(4'd3, d, d2, lat);
    tests_run++;
    if (lat != 4 || d !== 10'd3) begin
      tests_failed++;
      $display("FAIL bp_first: got data=%0d lat=%0d expected data=3 lat=4", d, lat);
    end
    // Offer a sample while stalled; it must not be taken.
    for (int c = 0; c < 10; c++) begin
      @(negedge clk);
      in_valid  = 1'b1;
      in_sample = 4'd7;
      @(posedge clk);
      #1;
      tests_run++;
      if (out_valid !== 1'b1 || out_data !== 10'd3 || in_ready !== 1'b0) begin
        tests_failed++;
        $display("FAIL bp_hold[%0d]: got valid=%b data=%0d in_ready=%b expected 1/3/0", c, out_valid, out_data, in_ready);
      end
    end
    @(negedge clk);
    in_valid  = 1'b0;
    in_sample = 4'd0;
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    tests_run++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
      tests_failed++;
      $display("FAIL bp_release: got valid=%b in_ready=%b expected 0/1", out_valid, in_ready);
    end
    push(4'd0, d, d2, lat);
    tests_run++;
    if (d !== 10'd6) begin
      tests_failed++;
      $display("FAIL bp_no_capture: got %0d expected 6", d);
    end
  endtask

  task automatic test_ignored_input;
    logic [9:0] expv [3] = '{10'd2, 10'd2, 10'd1};
    logic [9:0] d, d2;
    int lat;
    int n;
    do_reset;
    out_ready = 1'b1;
    @(negedge clk);
    in_valid  = 1'b1;
    in_sample = 4'd1;
    @(posedge clk);
    #1;
    in_sample = 4'd9;
    @(posedge clk);
    @(posedge clk);
    #1;
    in_valid  = 1'b0;
    in_sample = 4'd0;
    n = 0;
    while (!out_valid && n < 20) begin
      @(posedge clk);
      #1;
      n++;
    end
    tests_run++;
    if (out_valid !== 1'b1 || out_data !== 10'd1) begin
      tests_failed++;
      $display("FAIL ignored_first: got valid=%b data=%0d expected 1/1", out_valid, out_data);
    end
    for (int i = 0; i < 3; i++) begin
      push(4'd0, d, d2, lat);
      tests_run++;
      if (d !== expv[i]) begin
        tests_failed++;
        $display("FAIL ignored_later[%0d]: got %0d expected %0d", i, d, expv[i]);
      end
    end
  endtask

  task automatic test_reset_mid_mac;
    logic [9:0] d, d2;
    int lat;
    int n;
    do_reset;
    out_ready = 1'b1;
    push(4'd5, d, d2, lat);
    tests_run++;
    if (d !== 10'd5) begin
      tests_failed++;
      $display("FAIL midmac_pre: got %0d expected 5", d);
    end
    n = 0;
    @(negedge clk);
    while (!in_ready && n < 20) begin
      @(negedge clk);
      n++;
    end
    in_valid  = 1'b1;
    in_sample = 4'd15;
    @(posedge clk);
    #1;
    in_valid  = 1'b0;
    in_sample = 4'd0;
    @(posedge clk);
    @(posedge clk);
    #1;
    rst_n = 1'b0;
    #1;
    tests_run++;
    if (out_valid !== 1'b0 || out_data !== 10'd0 || in_ready !== 1'b1) begin
      tests_failed++;
      $display("FAIL midmac_reset: got valid=%b data=%0d in_ready=%b expected 0/0/1", out_valid, out_data, in_ready);
    end
    @(negedge clk);
    rst_n = 1'b1;
    push(4'd15, d, d2, lat);
    tests_run++;
    if (lat != 4 || d !== 10'd15) begin
      tests_failed++;
      $display("FAIL midmac_after: got data=%0d lat=%0d expected data=15 lat=4", d, lat);
    end
    push(4'd0, d, d2, lat);
    tests_run++;
    if (d !== 10'd30) begin
      tests_failed++;
      $display("FAIL midmac_history: got %0d expected 30", d);
    end
  endtask

  task automatic test_back_to_back;
    int         t [3];
    logic [9:0] v [3];
    int         k;
    do_reset;
    out_ready = 1'b1;
    k = 0;
    for (int i = 0; i < 3; i++) begin
      t[i] = -100;
      v[i] = '0;
    end
    @(negedge clk);
    in_valid  = 1'b1;
    in_sample = 4'd1;
    for (int c = 0; c < 30; c++) begin
      @(posedge clk);
      #1;
      if (out_valid && k < 3) begin
        t[k] = c;
        v[k] = out_data;
        k++;
      end
    end
    in_valid = 1'b0;
    tests_run++;
    if (t[1] - t[0] != 6 || t[2] - t[1] != 6) begin
      tests_failed++;
      $display("FAIL b2b_spacing: got %0d,%0d expected 6,6", t[1] - t[0], t[2] - t[1]);
    end
    tests_run++;
    if (v[0] !== 10'd1 || v[1] !== 10'd3 || v[2] !== 10'd5) begin
      tests_failed++;
      $display("FAIL b2b_data: got %0d,%0d,%0d expected 1,3,5", v[0], v[1], v[2]);
    end
  endtask

`ifdef FIR_FLUSH_EN
  task automatic test_flush;
    logic [9:0] d, d2;
    int lat;
    do_reset;
    out_ready = 1'b1;
    push(4'd15, d, d2, lat);
    push(4'd15, d, d2, lat);
    @(negedge clk);
    @(negedge clk);
    flush     = 1'b1;
    in_valid  = 1'b1;
    in_sample = 4'd7;
    @(posedge clk);
    #1;
    tests_run++;
    if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
      tests_failed++;
      $display("FAIL flush_not_accepted: got in_ready=%b valid=%b expected 1/0", in_ready, out_valid);
    end
    flush     = 1'b0;
    in_valid  = 1'b0;
    in_sample = 4'd0;
    push(4'd15, d, d2, lat);
    tests_run++;
    if (d !== 10'd15) begin
      tests_failed++;
      $display("FAIL flush_cleared: got %0d expected 15", d);
    end
  endtask
`endif

  initial begin
    test_reset;
    test_impulse;
    test_full_scale;
    test_backpressure;
    test_ignored_input;
    test_reset_mid_mac;
    test_back_to_back;
`ifdef FIR_FLUSH_EN
    test_flush;
`endif
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule

// File: doc/fir_mac_4tap.md
FIR_MAC_4TAP -- requirements
Module: fir_mac_4tap

Interface
REQ-001 The block SHALL have one clock, clk; reset is asynchronous and active-low, rst_n.
REQ-002 Parameter C0, default 4'd1, SHALL be the tap-0 coefficient (newest sample), unsigned 4-bit.
REQ-003 Parameter C1, default 4'd2, SHALL be the tap-1 coefficient, unsigned 4-bit.
REQ-004 Parameter C2, default 4'd2, SHALL be the tap-2 coefficient, unsigned 4-bit.
REQ-005 Parameter C3, default 4'd1, SHALL be the tap-3 coefficient (oldest sample), unsigned 4-bit.
REQ-006 clk  input  1  SHALL be the rising-edge clock for all state.
REQ-007 rst_n  input  1  SHALL be the asynchronous active-low reset.
REQ-008 in_valid  input  1  SHALL indicate that in_sample holds a new sample.
REQ-009 in_sample  input  4  SHALL be the unsigned input sample.
REQ-010 in_ready  output  1  SHALL indicate that the block can accept a sample this cycle.
REQ-011 out_valid  output  1  SHALL indicate that out_data holds a filter result.
REQ-012 out_data  output  10  SHALL be the unsigned result, sum of C_k*x_k for k=0..3.
REQ-013 out_ready  input  1  SHALL indicate that downstream consumes out_data this cycle.

Function
REQ-014 The FSM SHALL have states IDLE, MAC and HOLD; in_ready SHALL be 1 only in IDLE.
REQ-015 In IDLE, when in_valid&&in_ready, the delay line SHALL shift (x3<=x2, x2<=x1, x1<=x0, x0<=in_sample), the accumulator SHALL clear, the tap index SHALL go to 0, and the FSM SHALL go to MAC.
REQ-016 In MAC, one product per cycle SHALL come from a single mul_4bit instance (C_k x x_k, k = tap index 0..3) and be added into a 10-bit accumulator.
REQ-017 After the tap-3 cycle, out_data SHALL load the final sum, out_valid SHALL go to 1 and the FSM SHALL go to HOLD, which gives out_valid high exactly 4 edges after the acceptance edge.
REQ-018 In HOLD, out_data and out_valid SHALL stay stable until out_valid&&out_ready; on that edge out_valid SHALL clear and the FSM SHALL return to IDLE.
REQ-019 in_valid asserted outside IDLE SHALL be ignored, and the sample SHALL NOT be captured.
REQ-020 The arithmetic SHALL be unsigned with no truncation; the maximum 4*225=900 fits in 10 bits.
REQ-021 Back-to-back throughput SHALL be one sample per 6 cycles when out_ready is held at 1.

Reset
REQ-022 On rst_n low, at any time including mid-MAC, the block SHALL clear x0..x3, the accumulator, the tap index and out_data to 0, set out_valid to 0, and enter IDLE (in_ready=1 after release).
REQ-023 A partially accumulated result SHALL be discarded by reset and never presented.

Configuration
REQ-024 With FIR_FLUSH_EN defined, an input port flush (1 bit) SHALL be added; flush high in IDLE SHALL zero x0..x3 on the next edge, take priority over a simultaneous in_valid, and leave that sample unaccepted.
REQ-025 With FIR_FLUSH_EN defined, flush outside IDLE SHALL be ignored.
REQ-026 Without FIR_FLUSH_EN, the port SHALL be absent and the delay line SHALL clear only by reset.

Structure
REQ-027 Package fir_pkg SHALL hold the state encoding (IDLE=2'd0, MAC=2'd1, HOLD=2'd2), SAMPLE_W=4, PROD_W=8, ACC_W=10 and NTAPS=4.
REQ-028 The block SHALL instantiate exactly one existing mul_4bit (ports a, b, r) as its sub-module, with the coefficient and sample muxed by tap index.

Verification
REQ-029 Impulse: defaults, samples 15,0,0,0,0 with out_ready=1 -> out_data 15,30,30,15,0, each out_valid 4 edges after its acceptance.
REQ-030 Full scale: C0..C3=15, five samples of 15 -> fourth and later outputs 900, no wrap.
REQ-031 Backpressure: out_ready=0 for 10 cycles in HOLD -> out_data stable, in_ready=0, no new sample captured; out_ready=1 -> one handshake, then IDLE.
REQ-032 Reset mid-MAC: rst_n low at tap 2 -> out_valid=0, out_data=0; next impulse 15 -> 15, with no history from before reset.
REQ-033 With FIR_FLUSH_EN: load 15,15, assert flush with in_valid in IDLE -> sample not accepted; next sample 15 -> out_data 15.
REQ-034 Ignored input: in_valid pulsed during MAC with sample 9 -> the sample is absent from all later results.
